// File: rtl/tx_uart128_if.sv
// Handshake and serial-output bundle for the 128-bit UART transmitter.
// The driver uses the master modport; the transmitter itself uses the slave modport.
interface tx_uart128_if;
  logic         en_tx;
  logic [127:0] data_in;
  logic         u_tx;
  logic         u_tx_busy;
  logic         u_tx_done;

  modport master (
    output en_tx,
    output data_in,
    input  u_tx,
    input  u_tx_busy,
    input  u_tx_done
  );

  modport slave (
    input  en_tx,
    input  data_in,
    output u_tx,
    output u_tx_busy,
    output u_tx_done
  );
endinterface

// File: rtl/tx_uart128.sv
// Sends a 128-bit word as 16 back-to-back 8N1 frames, MSB byte first and LSB bit first.
// The line, busy and done outputs are all registered so the line is glitch-free.
module tx_uart128 #(
  parameter int CLKS_PER_BIT = 868
) (
  input logic           clk,
  input logic           rst,
  tx_uart128_if.slave   bus
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [3:0]    byte_cnt, byte_n;
  logic [127:0]  shreg, shreg_n;
  logic          tx_q, tx_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;

  logic       bit_end;
  logic [7:0] cur_byte;

  assign bit_end  = (baud == BAUD_MAX);
  assign cur_byte = shreg[127:120];

  // NOTE: every signal gets its default before the case statement, so no path
  // through this block can leave a value unassigned and infer a latch.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_cnt;
    byte_n  = byte_cnt;
    shreg_n = shreg;
    tx_n    = tx_q;
    busy_n  = busy_q;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (bus.en_tx) begin
          shreg_n = bus.data_in;
          byte_n  = '0;
          bit_n   = '0;
          baud_n  = '0;
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end

      // The line register is loaded with the value of the bit being entered,
      // so the transition edge and the new line level coincide.
      START: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = cur_byte[0];
        end else begin
          baud_n = baud + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_cnt + 3'd1;
            tx_n  = cur_byte[bit_cnt + 3'd1];
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (byte_cnt == 4'd15) begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            byte_n  = byte_cnt + 4'd1;
            shreg_n = {shreg[119:0], 8'h00};
            state_n = START;
            tx_n    = 1'b0;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: the shift register is a plain register rather than a memory array,
  // so it is cleared by reset along with the counters and no stale payload survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud     <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register take its new value
      // together at the edge, independent of statement order.
      baud     <= baud_n;
      bit_cnt  <= bit_n;
      byte_cnt <= byte_n;
      shreg    <= shreg_n;
      tx_q     <= tx_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  assign bus.u_tx      = tx_q;
  assign bus.u_tx_busy = busy_q;
  assign bus.u_tx_done = done_q;

endmodule

// File: tb/tb_tx_uart128.sv
// Self-checking bench for tx_uart128: a cycle-level line model, a UART decoder
// and literal timing checks, driven with randomized payloads and noise on en_tx/data_in.
module tb_tx_uart128;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int TOTAL = 16 * FRAME;

  logic clk = 1'b0;
  logic rst = 1'b0;
  tx_uart128_if bus();

  tx_uart128 #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: position inside the 16-frame transfer, counted in cycles.
  bit           m_active = 1'b0;
  bit           m_done   = 1'b0;
  int           m_t      = 0;
  logic [127:0] m_data   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_t      = 0;
    end else if (m_active) begin
      m_t++;
      if (m_t == TOTAL) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (bus.en_tx) begin
        m_active = 1'b1;
        m_t      = 0;
        m_data   = bus.data_in;
      end
    end
  end

  always @(negedge clk) begin
    logic         e_tx;
    logic [127:0] sh;
    int           f, b;
    if (m_active) begin
      f = m_t / FRAME;
      b = (m_t % FRAME) / CPB;
      if (b == 0)      e_tx = 1'b0;
      else if (b == 9) e_tx = 1'b1;
      else begin
        sh   = m_data >> (8 * (15 - f));
        e_tx = sh[b-1];
      end
      check("line", bus.u_tx, e_tx);
      check("busy", bus.u_tx_busy, 1'b1);
      check("done", bus.u_tx_done, 1'b0);
    end else begin
      check("line", bus.u_tx, 1'b1);
      check("busy", bus.u_tx_busy, 1'b0);
      check("done", bus.u_tx_done, m_done);
    end
  end

  // Independent UART receiver: finds each start bit and samples mid-bit.
  logic [7:0] rx_q[$];
  int         done_q[$];
  int         busy_cnt = 0;
  bit         rx_act   = 1'b0;
  int         rx_cnt   = 0;
  logic [7:0] rx_sh    = '0;

  always @(negedge clk) begin
    if (bus.u_tx_done) done_q.push_back(cyc);
    if (bus.u_tx_busy) busy_cnt++;
    if (rst) begin
      rx_act = 1'b0;
    end else begin
      if (!rx_act && bus.u_tx == 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end else if (rx_act) begin
        rx_cnt++;
      end
      if (rx_act) begin
        if (rx_cnt == 2) check("start_bit", bus.u_tx, 1'b0);
        if (rx_cnt >= CPB + 1 && rx_cnt <= 8 * CPB + 1 && (rx_cnt - CPB - 1) % CPB == 0)
          rx_sh[(rx_cnt - CPB - 1) / CPB] = bus.u_tx;
        if (rx_cnt == 9 * CPB + 1) check("stop_bit", bus.u_tx, 1'b1);
        if (rx_cnt == FRAME - 1) begin
          rx_q.push_back(rx_sh);
          rx_act = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_done(input int n0, input int budget, input bit noisy);
    int k = 0;
    while (done_q.size() <= n0 && k < budget) begin
      step();
      if (noisy) begin
        bus.en_tx = 1'($urandom_range(0, 1));
        bus.data_in = ($urandom_range(0, 3) == 0) ? {128{1'b1}} : rand128();
      end
      k++;
    end
    bus.en_tx = 1'b0;
    if (done_q.size() <= n0) check("done_timeout", 128'(done_q.size()), 128'(n0 + 1));
  endtask

  task automatic check_bytes(input string name, input logic [127:0] d, input int base);
    logic [127:0] sh;
    for (int i = 0; i < 16; i++) begin
      sh = d >> (8 * (15 - i));
      if (rx_q.size() > base + i) check(name, rx_q[base + i], sh[7:0]);
      else                       check(name, 128'(rx_q.size()), 128'(base + i + 1));
    end
  endtask

  task automatic run_xfer(input logic [127:0] d, input bit noisy);
    int n0, acc;
    rx_q.delete();
    n0 = done_q.size();
    step();
    bus.en_tx   = 1'b1;
    bus.data_in = d;
    busy_cnt    = 0;
    step();
    bus.en_tx = 1'b0;
    acc = cyc;
    wait_done(n0, TOTAL + 100, noisy);
    if (done_q.size() > n0) check("done_latency", 128'(done_q[n0] - acc), 128'(TOTAL));
    check("busy_cycles", 128'(busy_cnt), 128'(TOTAL));
    check("frame_count", 128'(rx_q.size()), 128'd16);
    check_bytes("frame_byte", d, 0);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] d, a, b2;
    int n0, acc2;

    bus.en_tx   = 1'b0;
    bus.data_in = '0;
    #1 rst = 1'b1;
    #2;
    check("reset_tx", bus.u_tx, 1'b1);
    check("reset_busy", bus.u_tx_busy, 1'b0);
    check("reset_done", bus.u_tx_done, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();

    // Reference pattern: frames must decode as 00,11,...,FF.
    run_xfer(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0);
    if (rx_q.size() == 16) begin
      check("first_frame", rx_q[0], 8'h00);
      check("last_frame", rx_q[15], 8'hFF);
    end

    // Noisy en_tx / data_in during busy must be ignored and not queued.
    for (int i = 0; i < 4; i++) begin
      run_xfer(rand128(), 1'b1);
      n0 = done_q.size();
      repeat ($urandom_range(1, 5)) step();
    end
    repeat (TOTAL + 60) step();
    check("no_queued_xfer", 128'(done_q.size()), 128'(n0));

    // Reset in frame 5 aborts with no done pulse; next transfer starts fresh.
    n0 = done_q.size();
    step();
    bus.en_tx   = 1'b1;
    bus.data_in = rand128();
    step();
    bus.en_tx = 1'b0;
    repeat (5 * FRAME + 17) step();
    rst = 1'b1;
    #1;
    check("async_rst_tx", bus.u_tx, 1'b1);
    check("async_rst_busy", bus.u_tx_busy, 1'b0);
    check("async_rst_done", bus.u_tx_done, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    repeat (TOTAL + 20) step();
    check("abort_no_done", 128'(done_q.size()), 128'(n0));
    d = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    run_xfer(d, 1'b0);
    if (rx_q.size() > 0) check("after_rst_first", rx_q[0], 8'hDE);

    // en_tx held high across two transfers: one idle cycle, done pulses 641 apart.
    a  = rand128();
    b2 = rand128();
    rx_q.delete();
    n0 = done_q.size();
    step();
    bus.en_tx   = 1'b1;
    bus.data_in = a;
    step();
    bus.data_in = b2;
    bus.en_tx   = 1'b1;
    while (done_q.size() <= n0 && cyc < 100_000) step();
    step();
    bus.en_tx = 1'b0;
    acc2 = cyc;
    wait_done(n0 + 1, TOTAL + 100, 1'b0);
    if (done_q.size() > n0 + 1) begin
      check("done_spacing", 128'(done_q[n0 + 1] - done_q[n0]), 128'(TOTAL + 1));
      check("second_accept", 128'(acc2 - done_q[n0]), 128'd1);
    end
    check("two_xfer_frames", 128'(rx_q.size()), 128'd32);
    check_bytes("xfer_a_byte", a, 0);
    check_bytes("xfer_b_byte", b2, 16);

    repeat (50) step();
    check("final_idle_done", 128'(done_q.size()), 128'(n0 + 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
